// File: rtl/ft245_rx_reader.sv
// FT245-style receive reader: strobes RD# while RXF# reports data, samples the chip bus
// and buffers the bytes in a small FIFO that feeds a valid/ready stream.
module ft245_rx_reader #(
    parameter int RD_PULSE   = 2,
    parameter int RD_RECOVER = 4,
    parameter int FIFO_LOG2  = 2
) (
    input  logic                 clk,
    input  logic                 reset_in,
    input  logic                 rxf,
    input  logic [7:0]           data_in,
    output logic                 rd,
    output logic [7:0]           rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [FIFO_LOG2:0]   fifo_level,
    output logic [15:0]          byte_count
);

    localparam int DEPTH   = 1 << FIFO_LOG2;
    localparam int CNT_MAX = (RD_PULSE > RD_RECOVER) ? RD_PULSE : RD_RECOVER;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]     PULSE_LOAD   = CNT_W'(RD_PULSE - 1);
    localparam logic [CNT_W-1:0]     RECOVER_LOAD = CNT_W'(RD_RECOVER - 1);
    localparam logic [CNT_W-1:0]     CNT_ONE      = 1;
    localparam logic [FIFO_LOG2:0]   LEVEL_FULL   = (FIFO_LOG2 + 1)'(DEPTH);
    localparam logic [FIFO_LOG2:0]   LEVEL_ONE    = 1;
    localparam logic [FIFO_LOG2-1:0] PTR_ONE      = 1;
    localparam logic [15:0]          COUNT_ONE    = 1;

    typedef enum logic [1:0] {IDLE, STROBE, RECOVER} state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic                 rxf_meta;
    logic                 rxf_s;
    logic [7:0]           mem [DEPTH];
    logic [FIFO_LOG2-1:0] wr_ptr;
    logic [FIFO_LOG2-1:0] rd_ptr;
    logic                 push;
    logic                 pop;

    assign push     = (state == STROBE) && (cnt == '0);
    assign rx_valid = (fifo_level != '0);
    assign pop      = rx_valid && rx_ready;
    assign rx_data  = mem[rd_ptr];

    // RXF# is asynchronous to clk; both flops idle high so reset never looks like "data ready"
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            rxf_meta <= 1'b1;
            rxf_s    <= 1'b1;
        end else begin
            rxf_meta <= rxf;
            rxf_s    <= rxf_meta;
        end
    end

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state      <= IDLE;
            cnt        <= '0;
            rd         <= 1'b1;
            byte_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rd <= 1'b1;
                    if (!rxf_s && (fifo_level < LEVEL_FULL)) begin
                        rd    <= 1'b0;
                        cnt   <= PULSE_LOAD;
                        state <= STROBE;
                    end
                end
                STROBE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else begin
                        rd         <= 1'b1;
                        byte_count <= byte_count + COUNT_ONE;
                        cnt        <= RECOVER_LOAD;
                        state      <= RECOVER;
                    end
                end
                RECOVER: begin
                    rd <= 1'b1;
                    if (cnt != '0) cnt <= cnt - CNT_ONE;
                    else           state <= IDLE;
                end
                default: begin
                    rd    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Reads only start with room to spare, so a push can never meet a full FIFO
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= data_in;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop) rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LEVEL_ONE;
                2'b01:   fifo_level <= fifo_level - LEVEL_ONE;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

endmodule
